// File: rtl/fir_seq_pkg.sv
// Shared types for the FIR micro-sequencer: micro-op encoding, FSM states
// and the "unused register address" helper.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_COPY = 2'b01,
        OP_LOAD = 2'b10,
        OP_ADD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EIDLE = 3'd1,
        ST_STORE = 3'd2,
        ST_SHIFT = 3'd3,
        ST_ACCUM = 3'd4
    } state_t;

    // All-ones address of width w, used to mark unused src/dest fields.
    function automatic logic [31:0] unused_addr(input int unsigned w);
        return (32'h0000_0001 << w) - 32'h0000_0001;
    endfunction

endpackage

// File: rtl/fir_step_counter.sv
// Step counter k = 0..MAX-1 shared by the SHIFT and ACCUM phases.
module fir_step_counter #(
    parameter int MAX = 4,
    localparam int KW = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [KW-1:0] k,
    output logic          terminal
);

    logic [KW-1:0] k_r;

    // Clear takes priority over increment so a phase change always restarts at 0.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            k_r <= {KW{1'b0}};
        end else if (en) begin
            k_r <= k_r + KW'(1);
        end else begin
            k_r <= k_r;
        end
    end

    assign k        = k_r;
    assign terminal = (k_r == KW'(MAX - 1));

endmodule

// File: rtl/fir_sequencer.sv
// N-tap FIR micro-sequencer: STORE, N window shifts, N accumulates per sample.
// Optional sticky overrun detection is compiled in with FIR_SEQ_OVERRUN_EN.
module fir_sequencer
    import fir_seq_pkg::*;
#(
    parameter int NUM_TAPS = 4,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dr,
    input  logic              overflow,
    output logic              cnt_up,
    output logic              modwait,
    output logic [1:0]        op,
    output logic [ADDR_W-1:0] src1,
    output logic [ADDR_W-1:0] src2,
    output logic [ADDR_W-1:0] dest,
    output logic              err,
    output logic              overrun
);

    localparam int KW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [ADDR_W-1:0] UNUSED     = ADDR_W'(unused_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] STAGE_ADDR = ADDR_W'(NUM_TAPS + 1);

    if (NUM_TAPS + 3 > 2 ** ADDR_W) begin : g_addr_chk
        $error("fir_sequencer: NUM_TAPS+3 exceeds register file size 2**ADDR_W");
    end
    if (NUM_TAPS < 2) begin : g_taps_chk
        $error("fir_sequencer: NUM_TAPS must be at least 2");
    end

    state_t        state_r;
    state_t        state_next_s;
    logic          cnt_clr_s;
    logic          cnt_en_s;
    logic [KW-1:0] k_s;
    logic          terminal_s;
    op_t           op_s;

    fir_step_counter #(.MAX(NUM_TAPS)) u_step (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr_s),
        .en       (cnt_en_s),
        .k        (k_s),
        .terminal (terminal_s)
    );

    // Next-state and step-counter control.
    always_comb begin
        state_next_s = state_r;
        cnt_clr_s    = 1'b1;
        cnt_en_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_EIDLE: begin
                if (dr) state_next_s = ST_STORE;
                else    state_next_s = state_r;
            end
            ST_STORE: begin
                if (dr) state_next_s = ST_SHIFT;
                else    state_next_s = ST_EIDLE;
            end
            ST_SHIFT: begin
                if (terminal_s) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    cnt_clr_s = 1'b0;
                    cnt_en_s  = 1'b1;
                end
            end
            ST_ACCUM: begin
                // The k=0 COPY cannot overflow, so only ADD steps may abort.
                if ((k_s != {KW{1'b0}}) && overflow) begin
                    state_next_s = ST_EIDLE;
                end else if (terminal_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    cnt_clr_s = 1'b0;
                    cnt_en_s  = 1'b1;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register; modwait is loaded from the next-state decode so it is
    // high exactly during the busy states.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            modwait <= 1'b0;
        end else begin
            state_r <= state_next_s;
            modwait <= (state_next_s == ST_STORE) || (state_next_s == ST_SHIFT) ||
                       (state_next_s == ST_ACCUM);
        end
    end

    // Micro-op decode from state and step counter.
    always_comb begin
        op_s   = OP_NOP;
        src1   = UNUSED;
        src2   = UNUSED;
        dest   = UNUSED;
        cnt_up = 1'b0;
        err    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                op_s = OP_NOP;
            end
            ST_EIDLE: begin
                err = 1'b1;
            end
            ST_STORE: begin
                op_s   = OP_LOAD;
                dest   = STAGE_ADDR;
                cnt_up = 1'b1;
            end
            ST_SHIFT: begin
                op_s = OP_COPY;
                src1 = ADDR_W'(k_s) + ADDR_W'(2);
                dest = ADDR_W'(k_s) + ADDR_W'(1);
            end
            ST_ACCUM: begin
                dest = {ADDR_W{1'b0}};
                if (k_s == {KW{1'b0}}) begin
                    op_s = OP_COPY;
                    src1 = ADDR_W'(1);
                end else begin
                    op_s = OP_ADD;
                    src1 = {ADDR_W{1'b0}};
                    src2 = ADDR_W'(k_s) + ADDR_W'(1);
                end
            end
            default: begin
                op_s = OP_NOP;
            end
        endcase
    end

    assign op = op_s;

`ifdef FIR_SEQ_OVERRUN_EN
    logic dr_prev_r;
    logic overrun_r;

    // A new dr edge while still busy means the input stage outran the filter.
    always_ff @(posedge clk) begin
        if (reset) begin
            dr_prev_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            dr_prev_r <= dr;
            if (state_next_s == ST_STORE) begin
                overrun_r <= 1'b0;
            end else if (dr && !dr_prev_r &&
                         ((state_r == ST_SHIFT) || (state_r == ST_ACCUM))) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign overrun = overrun_r;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fir_sequencer.sv
// Scoreboard bench for fir_sequencer (NUM_TAPS=4, ADDR_W=4).
module tb_fir_sequencer;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] ds;
        logic       cu;
        logic       er;
        logic       mw;
        logic       ov;
    } vec_t;

`ifdef FIR_SEQ_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dr = 1'b0;
    logic       overflow = 1'b0;
    logic       cnt_up, modwait, err, overrun;
    logic [1:0] op;
    logic [3:0] src1, src2, dest;

    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    always #5 clk = ~clk;

    fir_sequencer #(.NUM_TAPS(4), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .dr       (dr),
        .overflow (overflow),
        .cnt_up   (cnt_up),
        .modwait  (modwait),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .dest     (dest),
        .err      (err),
        .overrun  (overrun)
    );

    // Drive inputs for this cycle and queue the outputs expected in it.
    task automatic step(input logic r, input logic d, input logic o,
                        input logic [1:0] e_op, input logic [3:0] e_s1,
                        input logic [3:0] e_s2, input logic [3:0] e_ds,
                        input logic e_cu, input logic e_er, input logic e_mw,
                        input logic e_ov);
        vec_t v;
        @(posedge clk);
        #1;
        reset    = r;
        dr       = d;
        overflow = o;
        v = '{op: e_op, s1: e_s1, s2: e_s2, ds: e_ds, cu: e_cu, er: e_er,
              mw: e_mw, ov: e_ov & OVR_EN};
        exp_q.push_back(v);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        vec_t e;
        vec_t a;
        cycle = cycle + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{op: op, s1: src1, s2: src2, ds: dest, cu: cnt_up, er: err,
                  mw: modwait, ov: overrun};
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL outputs @cycle %0d: got op=%0d s1=%0d s2=%0d d=%0d cu=%0b err=%0b mw=%0b ovr=%0b, want op=%0d s1=%0d s2=%0d d=%0d cu=%0b err=%0b mw=%0b ovr=%0b",
                         cycle, a.op, a.s1, a.s2, a.ds, a.cu, a.er, a.mw, a.ov,
                         e.op, e.s1, e.s2, e.ds, e.cu, e.er, e.mw, e.ov);
            end
        end
    end

    initial begin
        // Reset and idle
        step(1, 0, 0, 0, 15, 15, 15, 0, 0, 0, 0);
        step(0, 0, 0, 0, 15, 15, 15, 0, 0, 0, 0);
        // Nominal sample: dr high for two cycles
        step(0, 1, 0, 0, 15, 15, 15, 0, 0, 0, 0);
        step(0, 1, 0, 2, 15, 15, 5, 1, 0, 1, 0);
        step(0, 0, 0, 1, 2, 15, 1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 3, 15, 2, 0, 0, 1, 0);
        step(0, 0, 0, 1, 4, 15, 3, 0, 0, 1, 0);
        step(0, 0, 0, 1, 5, 15, 4, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, 15, 0, 0, 0, 1, 0);
        step(0, 0, 0, 3, 0, 2, 0, 0, 0, 1, 0);
        step(0, 0, 0, 3, 0, 3, 0, 0, 0, 1, 0);
        step(0, 0, 0, 3, 0, 4, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 15, 15, 15, 0, 0, 0, 0);
        // Withdrawn sample
        step(0, 1, 0, 0, 15, 15, 15, 0, 0, 0, 0);
        step(0, 0, 0, 2, 15, 15, 5, 1, 0, 1, 0);
        step(0, 0, 0, 0, 15, 15, 15, 0, 1, 0, 0);
        step(0, 0, 0, 0, 15, 15, 15, 0, 1, 0, 0);
        step(0, 1, 0, 0, 15, 15, 15, 0, 1, 0, 0);
        step(0, 0, 0, 2, 15, 15, 5, 1, 0, 1, 0);
        step(0, 0, 0, 0, 15, 15, 15, 0, 1, 0, 0);
        // Overflow abort at ACCUM k=2 (overflow at k=0 ignored)
        step(0, 1, 0, 0, 15, 15, 15, 0, 1, 0, 0);
        step(0, 1, 0, 2, 15, 15, 5, 1, 0, 1, 0);
        for (int k = 0; k < 4; k++)
            step(0, 0, 0, 1, 4'(k + 2), 15, 4'(k + 1), 0, 0, 1, 0);
        step(0, 0, 1, 1, 1, 15, 0, 0, 0, 1, 0);
        step(0, 0, 0, 3, 0, 2, 0, 0, 0, 1, 0);
        step(0, 0, 1, 3, 0, 3, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 15, 15, 15, 0, 1, 0, 0);
        // Reset mid-ACCUM for two cycles, with dr high during reset
        step(0, 1, 0, 0, 15, 15, 15, 0, 1, 0, 0);
        step(0, 1, 0, 2, 15, 15, 5, 1, 0, 1, 0);
        for (int k = 0; k < 4; k++)
            step(0, 0, 0, 1, 4'(k + 2), 15, 4'(k + 1), 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, 15, 0, 0, 0, 1, 0);
        step(1, 0, 0, 3, 0, 2, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 15, 15, 15, 0, 0, 0, 0);
        step(0, 1, 0, 0, 15, 15, 15, 0, 0, 0, 0);
        // Back-to-back: dr held high, STORE pulses 10 cycles apart
        step(0, 1, 0, 2, 15, 15, 5, 1, 0, 1, 0);
        for (int k = 0; k < 4; k++)
            step(0, 1, 0, 1, 4'(k + 2), 15, 4'(k + 1), 0, 0, 1, 0);
        step(0, 1, 0, 1, 1, 15, 0, 0, 0, 1, 0);
        for (int k = 1; k < 4; k++)
            step(0, 1, 0, 3, 0, 4'(k + 1), 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 15, 15, 15, 0, 0, 0, 0);
        step(0, 1, 0, 2, 15, 15, 5, 1, 0, 1, 0);
        // Overrun: dr 0->1 during SHIFT k=1
        step(0, 0, 0, 1, 2, 15, 1, 0, 0, 1, 0);
        step(0, 1, 0, 1, 3, 15, 2, 0, 0, 1, 0);
        step(0, 0, 0, 1, 4, 15, 3, 0, 0, 1, 1);
        step(0, 0, 0, 1, 5, 15, 4, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1, 15, 0, 0, 0, 1, 1);
        for (int k = 1; k < 4; k++)
            step(0, 0, 0, 3, 0, 4'(k + 1), 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 15, 15, 15, 0, 0, 0, 1);
        step(0, 0, 0, 2, 15, 15, 5, 1, 0, 1, 0);
        step(0, 0, 0, 0, 15, 15, 15, 0, 1, 0, 0);
        step(0, 0, 0, 0, 15, 15, 15, 0, 1, 0, 0);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
